serial_sub_ctrl: RTL and testbench

Bit-serial subtractor controller.
- Sequences one 1-bit full-subtractor cell over a WIDTH-bit operand pair, LSB first, one bit per clock.
- Computes diff = a - b with final borrow.
- Sits between a requester (start/done handshake) and the shared 1-bit subtractor datapath cell, trading area for latency.

---
 rtl/serial_sub_ctrl_pkg.sv | 16 +
 rtl/serial_sub_ctrl_fs_1bit.sv | 13 +
 rtl/serial_sub_ctrl.sv | 138 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: state encodings and state width.
package serial_sub_ctrl_pkg;

  localparam int SUB_STATE_W = 2;

  localparam logic [SUB_STATE_W-1:0] SUB_IDLE = 2'd0;
  localparam logic [SUB_STATE_W-1:0] SUB_RUN  = 2'd1;
  localparam logic [SUB_STATE_W-1:0] SUB_DONE = 2'd2;

  typedef enum logic [SUB_STATE_W-1:0] {
    S_IDLE = SUB_IDLE,
    S_RUN  = SUB_RUN,
    S_DONE = SUB_DONE
  } sub_state_e;

endpackage

// File: rtl/serial_sub_ctrl_fs_1bit.sv
// Combinational 1-bit full subtractor cell: diff = a - b - bin, with borrow out.
module fs_1bit (
  input  logic a_in,
  input  logic b_in,
  input  logic borrow_in,
  output logic diff_out,
  output logic borrow_out
);

  assign diff_out   = a_in ^ b_in ^ borrow_in;
  assign borrow_out = (~a_in & b_in) | (~(a_in ^ b_in) & borrow_in);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: one fs_1bit cell walked LSB-first over WIDTH bits.
// Optional signed-overflow flag (ovf_out) enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             cell_diff, cell_brw;
  logic [WIDTH-1:0] res_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  fs_1bit u_fs (
    .a_in       (a_sh_q[0]),
    .b_in       (b_sh_q[0]),
    .borrow_in  (brw_q),
    .diff_out   (cell_diff),
    .borrow_out (cell_brw)
  );

  // The minuend register doubles as the result shift register: each consumed
  // LSB frees the MSB slot that receives the new diff bit.
  assign res_next = {cell_diff, a_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a_in[WIDTH-1];
          b_msb_d = b_in[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        a_sh_d = res_next;
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        brw_d  = cell_brw;
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          diff_d   = res_next;
          borrow_d = cell_brw;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy_out   = (state_q != S_IDLE);
  assign done_out   = (state_q == S_DONE);
  assign diff_out   = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf_out    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl (WIDTH=8).
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic         start_in = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy_out, done_out, borrow_out;
  logic [W-1:0] diff_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_diff = '0;
  logic         exp_brw  = 1'b0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start_in   (start_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf_out    (ovf_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full operation from IDLE: checks latency, busy window, output hold during RUN.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    a_in = a; b_in = b; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    a_in = 8'hC3; b_in = 8'h9E;
    for (int k = 1; k <= 9; k++) begin
      if (k < 9) begin
        chk({tag, "_run_busy"}, busy_out, 1);
        chk({tag, "_run_done"}, done_out, 0);
        chk({tag, "_run_hold"}, diff_out, exp_diff);
        tick();
      end else begin
        chk({tag, "_done"}, done_out, 1);
        chk({tag, "_busy9"}, busy_out, 1);
        chk({tag, "_diff"}, diff_out, ed);
        chk({tag, "_borrow"}, borrow_out, eb);
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, ovf_out, eo);
`endif
      end
    end
    exp_diff = ed; exp_brw = eb;
    tick();
    chk({tag, "_idle_busy"}, busy_out, 0);
    chk({tag, "_idle_done"}, done_out, 0);
    chk({tag, "_idle_hold"}, diff_out, ed);
    if (eo === 1'bx) $display("unused ovf expectation");
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst_in = 1'b0;
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_diff", diff_out, 0);
    chk("rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf_out, 0);
`endif

    run_op("t5A23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    run_op("t0001", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op("t8001", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("t3C3C", 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0);
    run_op("t00FF", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

    // Start while busy is ignored and not queued
    a_in = 8'h10; b_in = 8'h01; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      start_in = (k == 4);
      if (k == 4) begin a_in = 8'hFF; b_in = 8'h00; end
      chk("ign_done", done_out, (k == 9));
      if (k == 9) begin
        chk("ign_diff", diff_out, 8'h0F);
        chk("ign_borrow", borrow_out, 0);
      end
      tick();
    end
    start_in = 1'b0;

    // Reset mid-RUN abandons the operation
    a_in = 8'h5A; b_in = 8'h23; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("mrst_busy", busy_out, 0);
    chk("mrst_diff", diff_out, 0);
    chk("mrst_borrow", borrow_out, 0);
    for (int k = 0; k < 12; k++) begin
      chk("mrst_nodone", done_out, 0);
      tick();
    end
    exp_diff = '0; exp_brw = 1'b0;
    run_op("post_rst", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);

    // Back-to-back with start held high: one result every WIDTH+2 cycles
    a_in = 8'h05; b_in = 8'h03; start_in = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      chk("b2b_done", done_out, (k % 10 == 9));
      chk("b2b_diff", diff_out, (k >= 9) ? 8'h02 : 8'h37);
      chk("b2b_borrow", borrow_out, 0);
      tick();
    end
    start_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
